// File: rtl/mux_2_to_1_arb_pkg.sv
`ifndef MUX_2_TO_1_ARB_PKG_SV
`define MUX_2_TO_1_ARB_PKG_SV
`default_nettype none
// ============================================================================
// Module      : mux_2_to_1_arb_pkg
// Description : Shared constants for the 2-to-1 stream merger. The select
//               encoding matches the one used by demux_1_to_2 users.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_2_to_1_arb_pkg;

  // Source select encoding carried on out_select
  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  // Default datapath width
  localparam int DEFAULT_BITS = 16;

endpackage
`default_nettype wire
`endif

// File: rtl/mux_2_to_1_arb_rr_arb_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_2
// Description : Two-requester round-robin arbiter, purely combinational.
//               Under contention the side opposite last_grant wins; a single
//               requester always wins regardless of last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_2
  import mux_2_to_1_arb_pkg::*;
(
  input  logic req_x,
  input  logic req_y,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  // Pick the winner from the two requests and the previous grant
  always_comb begin
    grant_valid = req_x | req_y;
    grant       = SEL_X;
    if (req_x && req_y) begin
      grant = ~last_grant;
    end else if (req_y) begin
      grant = SEL_Y;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_2_to_1_arb.sv
`default_nettype none
// ============================================================================
// Module      : mux_2_to_1_arb
// Description : Registered 2-to-1 valid/ready stream merger with round-robin
//               arbitration. Each output word is tagged with its source.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2_to_1_arb
  import mux_2_to_1_arb_pkg::*;
#(
  parameter int bits = DEFAULT_BITS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [bits-1:0] in_x,
  input  logic            in_x_valid,
  output logic            in_x_ready,
  input  logic [bits-1:0] in_y,
  input  logic            in_y_valid,
  output logic            in_y_ready,
  output logic [bits-1:0] out,
  output logic            out_select,
  output logic            out_valid,
  input  logic            out_ready
);

  logic r_last_grant;
  logic w_load_en;
  logic w_grant_valid;
  logic w_grant;

  rr_arb_2 u_arb (
    .req_x       (in_x_valid),
    .req_y       (in_y_valid),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant       (w_grant)
  );

  // Output slot is free when empty or being drained; readys follow the grant
  always_comb begin
    w_load_en  = ~out_valid | out_ready;
    in_x_ready = w_load_en & w_grant_valid & (w_grant == SEL_X);
    in_y_ready = w_load_en & w_grant_valid & (w_grant == SEL_Y);
  end

  // Output register and round-robin history; data holds when nothing is granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out          <= '0;
      out_select   <= SEL_X;
      out_valid    <= 1'b0;
      r_last_grant <= SEL_Y;
    end else if (w_load_en) begin
      if (w_grant_valid) begin
        out          <= (w_grant == SEL_Y) ? in_y : in_x;
        out_select   <= w_grant;
        out_valid    <= 1'b1;
        r_last_grant <= w_grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
